// File: rtl/serial_digit_adder_pkg.sv
// serial_digit_adder_pkg: state encoding shared by the digit-serial adder
package serial_digit_adder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_digit_adder_rca_slice.sv
// rca_slice: N-bit combinational ripple-carry adder exposing the carry into its top bit
module rca_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         c_msb_in
);
  logic [N:0] c;
  always_comb begin
    c = {{N{1'b0}}, c_in};
    for (int i = 0; i < N; i++) c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign s        = a ^ b ^ c[N-1:0];
  assign c_out    = c[N];
  assign c_msb_in = c[N-1];
endmodule

// File: rtl/serial_digit_adder.sv
// serial_digit_adder: WIDTH-bit add/subtract processed DIGIT bits per clock, LSD first
module serial_digit_adder
  import serial_digit_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             overflow
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);
  state_t           state;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [DIGIT-1:0] sum;
  logic             c_nxt, c_msb;
  logic             accept;
  assign accept = start && state != ST_RUN;
  assign busy   = state == ST_RUN;
  assign done   = state == ST_DONE;
  rca_slice #(.N(DIGIT)) u_slice (
    .a        (a_r[idx*DIGIT +: DIGIT]),
    .b        (b_r[idx*DIGIT +: DIGIT]),
    .c_in     (carry),
    .s        (sum),
    .c_out    (c_nxt),
    .c_msb_in (c_msb)
  );
  // subtraction is a + ~b + 1: invert b once at acceptance and force the carry in
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= ST_IDLE;
      a_r      <= '0;
      b_r      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      s        <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b ^ {WIDTH{sub}};
      carry <= sub | c_in;
      idx   <= '0;
      state <= ST_RUN;
    end else if (state == ST_RUN) begin
      s[idx*DIGIT +: DIGIT] <= sum;
      carry <= c_nxt;
      idx   <= idx == LAST ? '0 : idx + IW'(1);
      if (idx == LAST) begin
        c_out    <= c_nxt;
        overflow <= c_nxt ^ c_msb;
        state    <= ST_DONE;
      end
    end else begin
      state <= ST_IDLE;
    end
endmodule

// File: tb/tb_serial_digit_adder.sv
// tb_serial_digit_adder: scoreboard bench for 16/4, 8/8 and 8/1 configurations
module tb_serial_digit_adder;
  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        v;
    int          cyc;
  } exp_t;

  logic clk = 1'b0, reset = 1'b1;
  logic start16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic busy16, done16, c16, v16;
  logic [15:0] s16;
  logic start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic busy8a, done8a, c8a, v8a, busy8b, done8b, c8b, v8b;
  logic [7:0] s8a, s8b;
  int cyc = 0, n_chk = 0, n_fail = 0;
  exp_t q16[$], q8a[$], q8b[$];
  exp_t e16, e8a, e8b;
  logic p16 = 1'b0, p8a = 1'b0, p8b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_digit_adder #(.WIDTH(16), .DIGIT(4)) d16 (
    .clk(clk), .reset(reset), .start(start16), .sub(sub16), .a(a16), .b(b16), .c_in(cin16),
    .busy(busy16), .done(done16), .s(s16), .c_out(c16), .overflow(v16));
  serial_digit_adder #(.WIDTH(8), .DIGIT(8)) d8a (
    .clk(clk), .reset(reset), .start(start8), .sub(1'b0), .a(a8), .b(b8), .c_in(1'b0),
    .busy(busy8a), .done(done8a), .s(s8a), .c_out(c8a), .overflow(v8a));
  serial_digit_adder #(.WIDTH(8), .DIGIT(1)) d8b (
    .clk(clk), .reset(reset), .start(start8), .sub(1'b0), .a(a8), .b(b8), .c_in(1'b0),
    .busy(busy8b), .done(done8b), .s(s8b), .c_out(c8b), .overflow(v8b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got done expected no done", nm);
  endtask

  always @(negedge clk) begin
    if (done16) begin
      if (q16.size() == 0) unexpected("d16 spurious");
      else begin
        e16 = q16.pop_front();
        chk("d16 s", 32'(s16), 32'(e16.s));
        chk("d16 c_out", 32'(c16), 32'(e16.c));
        chk("d16 overflow", 32'(v16), 32'(e16.v));
        chk("d16 latency", 32'(cyc - e16.cyc), 32'd4);
        chk("d16 done pulse", 32'(p16), 32'd0);
        chk("d16 busy at done", 32'(busy16), 32'd0);
      end
    end
    p16 = done16;
  end

  always @(negedge clk) begin
    if (done8a) begin
      if (q8a.size() == 0) unexpected("d8a spurious");
      else begin
        e8a = q8a.pop_front();
        chk("d8a s", 32'(s8a), 32'(e8a.s[7:0]));
        chk("d8a c_out", 32'(c8a), 32'(e8a.c));
        chk("d8a overflow", 32'(v8a), 32'(e8a.v));
        chk("d8a latency", 32'(cyc - e8a.cyc), 32'd1);
        chk("d8a done pulse", 32'(p8a), 32'd0);
      end
    end
    p8a = done8a;
  end

  always @(negedge clk) begin
    if (done8b) begin
      if (q8b.size() == 0) unexpected("d8b spurious");
      else begin
        e8b = q8b.pop_front();
        chk("d8b s", 32'(s8b), 32'(e8b.s[7:0]));
        chk("d8b c_out", 32'(c8b), 32'(e8b.c));
        chk("d8b overflow", 32'(v8b), 32'(e8b.v));
        chk("d8b latency", 32'(cyc - e8b.cyc), 32'd8);
        chk("d8b done pulse", 32'(p8b), 32'd0);
      end
    end
    p8b = done8b;
  end

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = q16.size() == 0 && q8a.size() == 0 && q8b.size() == 0;
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain timeout: got %0d pending expected 0", q16.size() + q8a.size() + q8b.size());
      q16.delete(); q8a.delete(); q8b.delete();
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sb, input logic ci,
                      input logic [15:0] es, input logic ec, input logic ev);
    @(negedge clk);
    a16 = a; b16 = b; sub16 = sb; cin16 = ci; start16 = 1'b1;
    @(posedge clk);
    #1;
    q16.push_back('{es, ec, ev, cyc});
    start16 = 1'b0;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] es, input logic ec, input logic ev);
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk);
    #1;
    q8a.push_back('{{8'h00, es}, ec, ev, cyc});
    q8b.push_back('{{8'h00, es}, ec, ev, cyc});
    start8 = 1'b0;
  endtask

  logic [15:0] bb_a[3] = '{16'h1111, 16'hF000, 16'h4000};
  logic [15:0] bb_b[3] = '{16'h2222, 16'h1000, 16'h4000};
  logic        bb_sub[3] = '{1'b0, 1'b0, 1'b1};
  logic [15:0] bb_s[3] = '{16'h3333, 16'h0000, 16'h0000};
  logic        bb_c[3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset busy", 32'(busy16), 32'd0);
    chk("reset done", 32'(done16), 32'd0);
    chk("reset s", 32'(s16), 32'd0);
    chk("reset c_out", 32'(c16), 32'd0);
    chk("reset overflow", 32'(v16), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    op16(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0); drain();
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); drain();
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); drain();
    op16(16'h0001, 16'h0002, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b0); drain();
    op16(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0); drain();
    op16(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1); drain();
    op16(16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0); drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a16 = bb_a[i]; b16 = bb_b[i]; sub16 = bb_sub[i]; cin16 = 1'b0; start16 = 1'b1;
      @(posedge clk);
      #1;
      q16.push_back('{bb_s[i], bb_c[i], 1'b0, cyc});
      repeat (4) @(posedge clk);
    end
    @(negedge clk);
    start16 = 1'b0;
    drain();
    op16(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0);
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    drain();
    op16(16'h5555, 16'h1111, 1'b0, 1'b0, 16'h6666, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    q16.delete();
    chk("abort busy", 32'(busy16), 32'd0);
    chk("abort done", 32'(done16), 32'd0);
    chk("abort s", 32'(s16), 32'd0);
    chk("abort c_out", 32'(c16), 32'd0);
    chk("abort overflow", 32'(v16), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    op16(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0); drain();
    op8(8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0); drain();
    op8(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1); drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
